// File: rtl/ascii_encode_fsm.sv
// Rewrites digit entries (0..9) of an external register file in place as ASCII and counts them.
// Optional build macro NONDIGIT_BLANK_EN: non-digit entries are overwritten with a space.
module ascii_encode_fsm #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8,
  parameter int BASE  = 48
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          go,
  output logic [AW-1:0] R_Addr,
  output logic          R_en,
  input  logic [DW-1:0] R_Data,
  output logic [AW-1:0] W_Addr,
  output logic          W_en,
  output logic [DW-1:0] W_Data,
  output logic [6:0]    count,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, RD, CHK, WR, NEXT, DONE} state_t;

  state_t        r_state;
  logic [AW-1:0] r_i;
  logic [DW-1:0] r_temp;
  logic [DW-1:0] r_wdata;
  logic [6:0]    r_count;
  logic          r_ren, r_wen, r_busy, r_done;
  logic          w_is_digit;

  assign w_is_digit = (r_temp < DW'(10));

  // Both ports follow the entry index; reads and writes never overlap in time.
  assign R_Addr = r_i;
  assign W_Addr = r_i;
  assign R_en   = r_ren;
  assign W_en   = r_wen;
  assign W_Data = r_wdata;
  assign count  = r_count;
  assign busy   = r_busy;
  assign done   = r_done;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_temp  <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ren <= 1'b0;
      r_wen <= 1'b0;
      case (r_state)
        IDLE: if (go) begin
          r_state <= RD;
          r_i     <= '0;
          r_count <= '0;
          r_ren   <= 1'b1;
          r_busy  <= 1'b1;
        end
        RD: begin
          r_temp  <= R_Data;
          r_state <= CHK;
        end
        CHK: begin
          if (w_is_digit) begin
            r_state <= WR;
            r_wen   <= 1'b1;
            r_wdata <= r_temp + DW'(BASE);
          end else begin
`ifdef NONDIGIT_BLANK_EN
            r_state <= WR;
            r_wen   <= 1'b1;
            r_wdata <= DW'(8'h20);
`else
            r_state <= NEXT;
`endif
          end
        end
        WR: begin
          // Blanked non-digits also pass through here but are not counted.
          if (w_is_digit) r_count <= r_count + 7'd1;
          r_state <= NEXT;
        end
        NEXT: begin
          if (r_i == AW'(DEPTH-1)) begin
            r_i     <= '0;
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_i     <= r_i + AW'(1);
            r_state <= RD;
            r_ren   <= 1'b1;
          end
        end
        DONE: if (!go) begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_encode_fsm.sv
// Bench for ascii_encode_fsm: behavioural register file plus a per-entry reference model.
module tb_ascii_encode_fsm;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       go  = 1'b0;
  logic [3:0] R_Addr, W_Addr;
  logic       R_en, W_en;
  logic [7:0] R_Data, W_Data;
  logic [6:0] count;
  logic       busy, done;

  ascii_encode_fsm dut (
    .Clk(Clk), .Rst(Rst), .go(go),
    .R_Addr(R_Addr), .R_en(R_en), .R_Data(R_Data),
    .W_Addr(W_Addr), .W_en(W_en), .W_Data(W_Data),
    .count(count), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  logic [7:0] rf    [16];
  logic [7:0] ld_rf [16];
  logic       load = 1'b0;
  int         wr_cnt  = 0;
  int         overlap = 0;
  int         nchk = 0;
  int         nerr = 0;

`ifdef NONDIGIT_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  assign R_Data = R_en ? rf[R_Addr] : 8'h00;

  always @(posedge Clk) begin
    if (load) rf <= ld_rf;
    else if (W_en) rf[W_Addr] <= W_Data;
    if (W_en) wr_cnt <= wr_cnt + 1;
    if (W_en && R_en) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_rf();
    @(negedge Clk) load = 1'b1;
    @(negedge Clk) load = 1'b0;
  endtask

  // Full run with a one-cycle go pulse; model result and latency derived per entry.
  task automatic do_run(input string tag);
    logic [7:0] exp_rf [16];
    int exp_cnt, exp_lat, lat;
    exp_cnt = 0; exp_lat = 0;
    for (int k = 0; k < 16; k++) begin
      if (rf[k] < 10) begin
        exp_rf[k] = rf[k] + 8'd48; exp_cnt++; exp_lat += 4;
      end else begin
        exp_rf[k] = BLANK ? 8'h20 : rf[k];
        exp_lat += BLANK ? 4 : 3;
      end
    end
    @(negedge Clk) go = 1'b1;
    @(posedge Clk); #1;
    chk({tag, "_busy"}, busy, 1);
    @(negedge Clk) go = 1'b0;
    lat = 201;
    for (int n = 1; n <= 200; n++) begin
      @(posedge Clk); #1;
      if (done) begin lat = n; break; end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_count"}, count, exp_cnt);
    chk({tag, "_busy_done"}, busy, 0);
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s_rf%0d", tag, k), rf[k], exp_rf[k]);
    @(posedge Clk); #1;
    chk({tag, "_back_idle"}, done, 0);
  endtask

  initial begin
    int lat, w0;
    logic [7:0] snap [16];

    // Reset state
    #12;
    chk("rst_R_en", R_en, 0);
    chk("rst_W_en", W_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_addr", {R_Addr, W_Addr}, 0);
    chk("rst_wdata", W_Data, 0);
    @(negedge Clk) Rst = 1'b0;

    // 1: digits then letters
    for (int k = 0; k < 16; k++) ld_rf[k] = (k < 10) ? 8'(k) : 8'(8'h41 + k - 10);
    load_rf();
    do_run("t1");

    // 2: boundaries
    for (int k = 0; k < 16; k++) ld_rf[k] = 8'h20;
    ld_rf[0] = 8'd0; ld_rf[1] = 8'd9; ld_rf[2] = 8'd10; ld_rf[3] = 8'hFF;
    load_rf();
    do_run("t2");

    // 3: no digits
    for (int k = 0; k < 16; k++) ld_rf[k] = 8'hFF;
    load_rf();
    do_run("t3");

    // Randomized contents, roughly half digits
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 16; k++)
        ld_rf[k] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(10, 255));
      load_rf();
      do_run($sformatf("rnd%0d", r));
    end

    // 4: reset mid-run at entry 5
    for (int k = 0; k < 16; k++) ld_rf[k] = 8'(k % 10);
    load_rf();
    @(negedge Clk) go = 1'b1;
    @(negedge Clk) go = 1'b0;
    lat = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge Clk); #1;
      if (R_Addr == 4'd5) begin lat = 1; break; end
    end
    chk("t4_reached_i5", lat, 1);
    Rst = 1'b1; #1;
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_ren", R_en, 0);
    chk("t4_rst_wen", W_en, 0);
    chk("t4_rst_count", count, 0);
    chk("t4_rst_addr", R_Addr, 0);
    @(negedge Clk) Rst = 1'b0;
    w0 = wr_cnt;
    repeat (5) @(posedge Clk);
    #1;
    chk("t4_idle_nowr", wr_cnt - w0, 0);
    chk("t4_idle_busy", busy, 0);
    for (int k = 0; k < 16; k++)
      chk($sformatf("t4_rf%0d", k), rf[k], (k < 5) ? 8'(k % 10 + 48) : 8'(k % 10));

    // 5: go held through DONE, then rerun over converted data
    for (int k = 0; k < 16; k++) ld_rf[k] = 8'(k % 10);
    load_rf();
    @(negedge Clk) go = 1'b1;
    lat = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge Clk); #1;
      if (done) begin lat = 1; break; end
    end
    chk("t5_done_seen", lat, 1);
    for (int k = 0; k < 16; k++) snap[k] = rf[k];
    w0 = wr_cnt;
    repeat (10) @(posedge Clk);
    #1;
    chk("t5_hold_done", done, 1);
    chk("t5_hold_nowr", wr_cnt - w0, 0);
    chk("t5_hold_count", count, 16);
    @(negedge Clk) go = 1'b0;
    @(posedge Clk); #1;
    chk("t5_drop_done", done, 0);
    chk("t5_drop_busy", busy, 0);
    for (int k = 0; k < 16; k++) chk($sformatf("t5_snap%0d", k), rf[k], snap[k]);
    do_run("t5_rerun");

    chk("no_rw_overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
